// File: rtl/ctrl_seq_if.sv
// ctrl_seq_if: control-sequencer bus between the fetch/ALU side (master) and the sequencer (slave)
interface ctrl_seq_if #(
  parameter int INSTR_W = 9,
  parameter int PCT_W   = 4,
  parameter int CNT_W   = 16
);
  logic               Start;
  logic [INSTR_W-1:0] Instruction;
  logic               AluZero;
  logic               AluNeg;
  logic               Jump;
  logic               Branch;
  logic               BranchTaken;
  logic               MemRead;
  logic               MemtoReg;
  logic               MemWrite;
  logic               ALUSrc;
  logic               RegWrite;
  logic               RegDst;
  logic [3:0]         ALUOp;
  logic [PCT_W-1:0]   PCTarg;
  logic               PCEn;
  logic               Done;
  logic [CNT_W-1:0]   CycleCount;
  modport master (
    output Start, Instruction, AluZero, AluNeg,
    input  Jump, Branch, BranchTaken, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, RegDst,
    input  ALUOp, PCTarg, PCEn, Done, CycleCount
  );
  modport slave (
    input  Start, Instruction, AluZero, AluNeg,
    output Jump, Branch, BranchTaken, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, RegDst,
    output ALUOp, PCTarg, PCEn, Done, CycleCount
  );
endinterface

// File: rtl/ctrl_seq.sv
// ctrl_seq: multi-cycle control sequencer with flag register, internal branch resolution and halt
module ctrl_seq #(
  parameter int INSTR_W = 9,
  parameter int PCT_W   = 4,
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 16
) (
  input logic       Clk,
  input logic       Reset,
  ctrl_seq_if.slave bus
);
  localparam int MW = $clog2(MEM_LAT + 1);
  typedef enum logic [2:0] {IDLE, EXEC, MEM, WB, HALT} state_t;
  state_t           state_q, state_d;
  logic             flag_z_q, flag_z_d, flag_n_q, flag_n_d;
  logic [MW-1:0]    mem_cnt_q, mem_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op;
  logic [1:0]       fn;
  logic             is_ld, is_st, cond, mem_last, active;
  assign op       = bus.Instruction[INSTR_W-1 -: 3];
  assign fn       = bus.Instruction[1:0];
  assign is_ld    = op == 3'b110 && fn == 2'b00;
  assign is_st    = op == 3'b110 && fn == 2'b01;
  assign mem_last = mem_cnt_q == MW'(MEM_LAT - 1);
  assign active   = state_q == EXEC || state_q == MEM || state_q == WB;
  assign cond     = fn == 2'b00 ? flag_z_q : fn == 2'b01 ? !flag_z_q : fn == 2'b10 ? flag_n_q : 1'b1;
  assign bus.PCTarg     = bus.Instruction[PCT_W+1:2];
  assign bus.CycleCount = cnt_q;
  always_comb begin
    bus.Jump        = 1'b0;
    bus.Branch      = 1'b0;
    bus.BranchTaken = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.ALUSrc      = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.ALUOp       = 4'b0000;
    bus.PCEn        = 1'b0;
    bus.Done        = 1'b0;
    state_d         = state_q;
    flag_z_d        = flag_z_q;
    flag_n_d        = flag_n_q;
    mem_cnt_d       = '0;
    cnt_d           = active && !(&cnt_q) ? cnt_q + 1'b1 : cnt_q;
    case (state_q)
      IDLE: state_d = bus.Start ? EXEC : IDLE;
      EXEC: begin
        bus.ALUOp    = 4'b1000;
        bus.RegWrite = 1'b1;
        bus.PCEn     = 1'b1;
        case (op)
          3'b000: bus.ALUOp = {2'b00, fn};
          3'b001: begin
            bus.ALUOp  = fn == 2'b00 ? 4'b1001 : fn == 2'b01 ? 4'b1010 : fn == 2'b10 ? 4'b0100 : 4'b0101;
            bus.RegDst = fn == 2'b00;
          end
          3'b010: begin
            bus.ALUSrc = 1'b1;
            bus.ALUOp  = 4'b1010;
          end
          3'b011: bus.ALUOp = fn == 2'b00 ? 4'b0110 : fn == 2'b01 ? 4'b0111 : fn == 2'b10 ? 4'b1011 : 4'b1000;
          3'b100: begin
            bus.Branch   = 1'b1;
            bus.RegWrite = 1'b0;
            bus.ALUOp    = 4'b1001;
          end
          3'b101: begin
            bus.Jump     = fn == 2'b00;
            bus.RegWrite = fn != 2'b00;
            bus.ALUOp    = fn == 2'b01 ? 4'b0001 : 4'b1000;
            flag_z_d     = fn == 2'b01 ? bus.AluZero : flag_z_q;
            flag_n_d     = fn == 2'b01 ? bus.AluNeg : flag_n_q;
          end
          3'b110: begin
            bus.PCEn = !(is_ld || is_st);
            state_d  = is_ld || is_st ? MEM : EXEC;
          end
          default: begin
            bus.ALUOp    = 4'b0000;
            bus.RegWrite = 1'b0;
            bus.PCEn     = 1'b0;
            state_d      = HALT;
          end
        endcase
        bus.BranchTaken = bus.Jump || (bus.Branch && cond);
      end
      MEM: begin
        // Instruction is held by fetch while PCEn=0, so ld/str is re-decoded here
        bus.ALUOp    = 4'b1001;
        bus.MemRead  = is_ld;
        bus.MemWrite = is_st;
        bus.PCEn     = mem_last && !is_ld;
        mem_cnt_d    = mem_last ? '0 : mem_cnt_q + 1'b1;
        state_d      = !mem_last ? MEM : is_ld ? WB : EXEC;
      end
      WB: begin
        bus.ALUOp    = 4'b1000;
        bus.MemtoReg = 1'b1;
        bus.RegWrite = 1'b1;
        bus.PCEn     = 1'b1;
        state_d      = EXEC;
      end
      HALT: bus.Done = 1'b1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      flag_z_q  <= 1'b0;
      flag_n_q  <= 1'b0;
      mem_cnt_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      flag_z_q  <= flag_z_d;
      flag_n_q  <= flag_n_d;
      mem_cnt_q <= mem_cnt_d;
      cnt_q     <= cnt_d;
    end
  end
endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: scoreboard bench; per-cycle expectations queued by the driver, checked at negedge
module tb_ctrl_seq;
  logic Clk = 1'b0;
  logic Reset;
  int   n_vec = 0;
  int   n_err = 0;
  logic [15:0] exp_cnt = 16'd0;
  typedef struct {
    string       tag;
    logic [14:0] ctl;
    logic [3:0]  targ;
    logic [15:0] cnt;
  } exp_t;
  exp_t sb[$];
  exp_t e_m;
  // s = {Jump,Branch,BranchTaken,MemRead,MemtoReg,MemWrite,ALUSrc,RegWrite,RegDst,PCEn,Done}
  localparam logic [10:0] S0     = 11'b00000000000;
  localparam logic [10:0] S_ALU  = 11'b00000001010;
  localparam logic [10:0] S_RD   = 11'b00000001110;
  localparam logic [10:0] S_IMM  = 11'b00000011010;
  localparam logic [10:0] S_MEMX = 11'b00000001000;
  localparam logic [10:0] S_LDM  = 11'b00010000000;
  localparam logic [10:0] S_WB   = 11'b00001001010;
  localparam logic [10:0] S_BR   = 11'b01000000010;
  localparam logic [10:0] S_BRT  = 11'b01100000010;
  localparam logic [10:0] S_JMP  = 11'b10100000010;
  localparam logic [10:0] S_STM  = 11'b00000100000;
  localparam logic [10:0] S_STL  = 11'b00000100010;
  localparam logic [10:0] S_HLT  = 11'b00000000001;
  localparam logic [8:0]  ADD    = 9'b000_0000_00;
  localparam logic [8:0]  CMP    = 9'b101_0000_01;
  ctrl_seq_if #(.INSTR_W(9), .PCT_W(4), .CNT_W(16)) bus ();
  ctrl_seq_if #(.INSTR_W(9), .PCT_W(4), .CNT_W(4))  sbus ();
  assign sbus.Start       = bus.Start;
  assign sbus.Instruction = bus.Instruction;
  assign sbus.AluZero     = bus.AluZero;
  assign sbus.AluNeg      = bus.AluNeg;
  ctrl_seq #(.INSTR_W(9), .PCT_W(4), .MEM_LAT(2), .CNT_W(16)) u_dut (.Clk(Clk), .Reset(Reset), .bus(bus));
  ctrl_seq #(.INSTR_W(9), .PCT_W(4), .MEM_LAT(2), .CNT_W(4))  u_sat (.Clk(Clk), .Reset(Reset), .bus(sbus));
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input string tag, input logic st, input logic rs, input logic [8:0] ins,
                      input logic az, input logic an, input logic [10:0] s, input logic [3:0] alu,
                      input logic act);
    exp_t e;
    @(posedge Clk);
    #1;
    Reset           = rs;
    bus.Start       = st;
    bus.Instruction = ins;
    bus.AluZero     = az;
    bus.AluNeg      = an;
    e.tag  = tag;
    e.ctl  = {s[10:2], alu, s[1:0]};
    e.targ = ins[5:2];
    e.cnt  = exp_cnt;
    sb.push_back(e);
    exp_cnt = rs ? 16'd0 : (act && exp_cnt != 16'hffff) ? exp_cnt + 16'd1 : exp_cnt;
  endtask
  always @(negedge Clk) begin
    if (sb.size() != 0) begin
      e_m = sb.pop_front();
      chk({e_m.tag, "/ctl"}, 32'({bus.Jump, bus.Branch, bus.BranchTaken, bus.MemRead, bus.MemtoReg,
          bus.MemWrite, bus.ALUSrc, bus.RegWrite, bus.RegDst, bus.ALUOp, bus.PCEn, bus.Done}), 32'(e_m.ctl));
      chk({e_m.tag, "/targ"}, 32'(bus.PCTarg), 32'(e_m.targ));
      chk({e_m.tag, "/cnt"}, 32'(bus.CycleCount), 32'(e_m.cnt));
      chk({e_m.tag, "/sat"}, 32'(sbus.CycleCount), e_m.cnt > 16'd15 ? 32'd15 : 32'(e_m.cnt));
    end
  end
  initial begin
    Reset = 1'b1;
    bus.Start = 1'b0;
    bus.Instruction = '0;
    bus.AluZero = 1'b0;
    bus.AluNeg = 1'b0;
    repeat (2) @(posedge Clk);
    step("idle",    0, 0, ADD,          0, 0, S0,     4'b0000, 0);
    step("start",   1, 0, ADD,          0, 0, S0,     4'b0000, 0);
    step("add",     1, 0, ADD,          0, 0, S_ALU,  4'b0000, 1);
    step("sub",     1, 0, 9'b000_0000_01, 0, 0, S_ALU, 4'b0001, 1);
    step("mov",     0, 0, 9'b001_0000_00, 0, 0, S_RD,  4'b1001, 1);
    step("set",     0, 0, 9'b001_0000_01, 0, 0, S_ALU, 4'b1010, 1);
    step("xor",     0, 0, 9'b001_0000_10, 0, 0, S_ALU, 4'b0100, 1);
    step("not",     0, 0, 9'b001_0000_11, 0, 0, S_ALU, 4'b0101, 1);
    step("seti",    0, 0, 9'b010_0011_00, 0, 0, S_IMM, 4'b1010, 1);
    step("op3_0",   0, 0, 9'b011_0000_00, 0, 0, S_ALU, 4'b0110, 1);
    step("op3_2",   0, 0, 9'b011_0000_10, 0, 0, S_ALU, 4'b1011, 1);
    step("op3_3",   0, 0, 9'b011_0000_11, 0, 0, S_ALU, 4'b1000, 1);
    step("ld_x",    0, 0, 9'b110_0000_00, 0, 0, S_MEMX, 4'b1000, 1);
    step("ld_m1",   0, 0, 9'b110_0000_00, 0, 0, S_LDM, 4'b1001, 1);
    step("ld_m2",   0, 0, 9'b110_0000_00, 0, 0, S_LDM, 4'b1001, 1);
    step("ld_wb",   0, 0, 9'b110_0000_00, 0, 0, S_WB,  4'b1000, 1);
    step("cmp_z1",  0, 0, CMP,          1, 0, S_ALU,  4'b0001, 1);
    step("beq_t",   0, 0, 9'b100_0101_00, 0, 0, S_BRT, 4'b1001, 1);
    step("cmp_n1",  0, 0, CMP,          0, 1, S_ALU,  4'b0001, 1);
    step("beq_nt",  0, 0, 9'b100_0101_00, 1, 0, S_BR,  4'b1001, 1);
    step("bne_t",   0, 0, 9'b100_0101_01, 0, 0, S_BRT, 4'b1001, 1);
    step("bmi_t",   0, 0, 9'b100_0101_10, 0, 0, S_BRT, 4'b1001, 1);
    step("cmp_z1b", 0, 0, CMP,          1, 0, S_ALU,  4'b0001, 1);
    step("bmi_nt",  0, 0, 9'b100_0101_10, 0, 1, S_BR,  4'b1001, 1);
    step("bne_nt",  0, 0, 9'b100_0101_01, 0, 0, S_BR,  4'b1001, 1);
    step("bal",     0, 0, 9'b100_1010_11, 0, 0, S_BRT, 4'b1001, 1);
    step("jmp",     0, 0, 9'b101_1010_00, 0, 0, S_JMP, 4'b1000, 1);
    step("st_x",    0, 0, 9'b110_0000_01, 0, 0, S_MEMX, 4'b1000, 1);
    step("st_m1",   0, 0, 9'b110_0000_01, 0, 0, S_STM, 4'b1001, 1);
    step("st_m2",   0, 1, 9'b110_0000_01, 0, 0, S_STL, 4'b1001, 1);
    step("rst_idle", 1, 0, 9'b100_0101_00, 0, 0, S0,   4'b0000, 0);
    step("beq_clr", 0, 0, 9'b100_0101_00, 0, 0, S_BR,  4'b1001, 1);
    step("halt",    0, 0, 9'b111_0000_00, 0, 0, S0,    4'b0000, 1);
    step("hlt1",    1, 0, 9'b111_0000_00, 0, 0, S_HLT, 4'b0000, 0);
    step("hlt2",    0, 0, ADD,          0, 0, S_HLT,  4'b0000, 0);
    step("hlt3",    1, 0, ADD,          0, 0, S_HLT,  4'b0000, 0);
    step("hlt_rst", 0, 1, ADD,          0, 0, S_HLT,  4'b0000, 0);
    step("idle2",   1, 0, ADD,          0, 0, S0,     4'b0000, 0);
    for (int i = 0; i < 20; i++) step("sat", 0, 0, ADD, 0, 0, S_ALU, 4'b0000, 1);
    repeat (2) @(negedge Clk);
    chk("drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
